// File: rtl/mpy_pkg.sv
// rtl/mpy_pkg.sv - shared types and arithmetic helpers for the multiplier back end
package mpy_pkg;

    localparam int PROD_W = 8;

    // HOLD is not a state: it is carried by sum_valid, orthogonal to IDLE/ACC.
    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    // Sign-extend a product to 32 bits; callers narrow it to their accumulator width.
    function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(32 - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/mpy_acc_ctrl.sv
// rtl/mpy_acc_ctrl.sv - term counter, group state and input/output handshake
module mpy_acc_ctrl
    import mpy_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             p_valid_i,
    input  logic             sum_ready_i,
    output logic             p_ready_o,
    output logic             acc_en_o,
    output logic             final_o,
    output logic             sum_valid_o,
    output logic [CNT_W-1:0] term_cnt_o
);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sum_valid_q, sum_valid_d;
    logic             last_term;

    assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

    // A pending sum only blocks input if the consumer is not taking it this cycle.
    assign p_ready_o = !clr_i && (!sum_valid_q || sum_ready_i);
    assign acc_en_o  = p_valid_i && p_ready_o;
    assign final_o   = acc_en_o && last_term;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_valid_d = sum_valid_q;
        if (clr_i || final_o) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (acc_en_o) begin
            state_d = ACC;
            cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        // A final accept wins over sum_ready so back-to-back groups keep full rate.
        if (final_o) begin
            sum_valid_d = 1'b1;
        end else if (sum_ready_i) begin
            sum_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_valid_o = sum_valid_q;
    assign term_cnt_o  = cnt_q;

endmodule

// File: rtl/mpy_acc.sv
// rtl/mpy_acc.sv - accumulates N_TERMS signed products per group into a handshaked sum
module mpy_acc
    import mpy_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              p_valid,
    input  logic [PROD_W-1:0] p,
    output logic              p_ready,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_ovf,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  term_cnt
);

    logic             acc_en;
    logic             final_acc;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_next;
    logic             add_ov;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_ovf_q, sum_ovf_d;

    mpy_acc_ctrl #(
        .N_TERMS (N_TERMS),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .p_valid_i   (p_valid),
        .sum_ready_i (sum_ready),
        .p_ready_o   (p_ready),
        .acc_en_o    (acc_en),
        .final_o     (final_acc),
        .sum_valid_o (sum_valid),
        .term_cnt_o  (term_cnt)
    );

    assign p_ext    = ACC_W'(sext_prod(p));
    assign acc_next = acc_q + p_ext;
    assign add_ov   = add_ovf(acc_q[ACC_W-1], p_ext[ACC_W-1], acc_next[ACC_W-1]);

    always_comb begin
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        if (clr) begin
            acc_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (final_acc) begin
            sum_d     = acc_next;
            sum_ovf_d = ovf_acc_q || add_ov;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (acc_en) begin
            acc_d     = acc_next;
            ovf_acc_d = ovf_acc_q || add_ov;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

    assign sum     = sum_q;
    assign sum_ovf = sum_ovf_q;

endmodule

// File: doc/mpy_acc.md
Name: mpy_acc

Overview:
- Downstream consumer of the 4x4 Booth multiplier (MPY) output.
- Accepts a stream of signed 8-bit products through a valid/ready handshake.
- Accumulates N_TERMS products per group into a signed ACC_W-bit sum, then presents the sum on a valid/ready output port.
- Forms the multiply-accumulate back end of the dot-product datapath; upstream control aligns p_valid with the multiplier pipeline latency.

Parameters:
- N_TERMS, 4, products per group; legal range 1..255.
- ACC_W, 12, accumulator and sum width in bits; must be >= 8.
- CNT_W, 8, width of the term counter; must hold N_TERMS-1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous abort of the partial group.
- p_valid  in  1  product valid.
- p  in  8  signed two's-complement product.
- p_ready  out  1  block can accept a product this cycle.
- sum_valid  out  1  sum available.
- sum  out  ACC_W  signed group sum.
- sum_ovf  out  1  the group overflowed ACC_W; qualified by sum_valid.
- sum_ready  in  1  consumer takes the sum.
- term_cnt  out  CNT_W  products accepted in the current group.

Behaviour:
- Reset (rst=1 at an edge): acc=0, term_cnt=0, state=IDLE, sum=0, sum_valid=0, sum_ovf=0, ovf_acc=0.
  - rst overrides every other input.
  - A pending sum is discarded.
- Accept condition: acc_en = p_valid & p_ready.
  - p_ready = !clr & (!sum_valid | sum_ready).
  - p_ready is purely combinational; it has no dependency on p_valid.
- Arithmetic:
  - next = acc + sext(p, ACC_W); results wrap modulo 2^ACC_W.
  - Overflow is detected on each add when both operand signs are equal and the result sign differs.
  - ovf_acc is sticky OR across the group.
- States: IDLE (term_cnt=0), ACC (0<term_cnt<N_TERMS), HOLD (sum_valid=1). HOLD is orthogonal to IDLE/ACC: a new group may accumulate while HOLD is waiting.
- Non-final accept (term_cnt < N_TERMS-1):
  - acc <= next, term_cnt++, IDLE->ACC.
- Final accept (term_cnt == N_TERMS-1):
  - sum <= next.
  - sum_ovf <= ovf_acc | this add's overflow.
  - sum_valid <= 1.
  - acc <= 0, term_cnt <= 0, ovf_acc <= 0, state returns to IDLE.
  - Latency: sum_valid rises the cycle after the last product is accepted.
- Output handshake:
  - sum and sum_ovf stay stable while sum_valid & !sum_ready.
  - sum_valid & sum_ready with no final accept in the same cycle -> sum_valid <= 0 next cycle.
  - Final accept in the same cycle as sum_ready -> the new sum loads and sum_valid stays 1, so back-to-back groups run at full throughput.
- N_TERMS=1: every accept is a final accept; one sum per product.
- clr=1:
  - acc, term_cnt and ovf_acc are cleared; the partial group is dropped.
  - p_ready is forced low, so no product is consumed that cycle.
  - The pending sum, sum_valid and sum_ovf are unaffected.
  - sum_ready is still honoured in a clr cycle.
- p_valid with p_ready=0: the product is not consumed. Upstream holds it; this block does not buffer it.
- No X propagation: all registers are reset; the outputs are registers, except p_ready.

Decomposition:
- Shared package mpy_pkg:
  - PROD_W=8.
  - State enum {IDLE, ACC}. HOLD is represented by sum_valid.
  - Function sext_prod(p, ACC_W).
  - Function add_ovf(a, b, s).
- One natural sub-module: mpy_acc_ctrl, containing the term counter, state and p_ready/sum_valid handshake logic. The adder and registers stay in mpy_acc.

Test Plan:
- Reset: hold rst 2 cycles with p_valid=1 -> sum_valid=0, sum=0, term_cnt=0; p_ready=1 after rst drops.
- Back-to-back group (N_TERMS=4), sum_ready=1, p = 8'h07, 8'hF8, 8'h40, 8'hC0 on consecutive cycles -> 1 cycle after the 4th: sum_valid=1 for 1 cycle, sum=12'hFFF (-1), sum_ovf=0; term_cnt sequence is 1,2,3,0.
- Backpressure: sum_ready=0, group of four 8'h40 -> sum=12'h100 held stable, p_ready=0 while pending. Raise sum_ready with a new product presented -> that product is accepted that cycle and sum_valid drops the next cycle.
- Abort: accept 8'h10, 8'h10, then pulse clr with p_valid=1 and p=8'h55 -> 8'h55 not consumed (p_ready=0), term_cnt=0. Then 8'h01 x4 -> sum=12'h004.
- Overflow (ACC_W=8): 8'h40, 8'h40, 8'h00, 8'h00 -> sum=8'h80, sum_ovf=1. The next group 8'h01 x4 -> sum=8'h04, sum_ovf=0.
- Reset mid-operation: a sum is pending (sum_valid=1, sum_ready=0) and 2 terms are accumulated; assert rst for 1 cycle -> next cycle sum_valid=0, sum=0, term_cnt=0.
